// File: rtl/mod_ptr_counter.sv
// Modulo up/down pointer counter with clear, checked parallel load and look-ahead.
// Define MOD_PTR_COUNTER_SAT_EN to saturate at the ends instead of wrapping.
module mod_ptr_counter #(
  parameter int C_WIDTH = 4,
  parameter int C_DEPTH = 16,
  parameter int C_INIT  = 0
) (
  input  logic               c_clk,
  input  logic               c_reset,
  input  logic               en,
  input  logic               dir,
  input  logic               clr,
  input  logic               ld,
  input  logic [C_WIDTH-1:0] ld_val,
  output logic [C_WIDTH-1:0] c_out,
  output logic [C_WIDTH-1:0] c_next,
  output logic               c_wrap,
  output logic               tc,
  output logic               ld_err
);

  localparam logic [C_WIDTH:0]   DEPTH_X = (C_WIDTH+1)'(C_DEPTH);
  localparam logic [C_WIDTH:0]   ONE_X   = (C_WIDTH+1)'(1);
  localparam logic [C_WIDTH-1:0] TOP_V   = C_WIDTH'(C_DEPTH - 1);
  localparam logic [C_WIDTH-1:0] INIT_V  = C_WIDTH'(C_INIT);

  logic [C_WIDTH-1:0] ptr_q, ptr_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;
  logic [C_WIDTH:0]   up_x;
  logic [C_WIDTH:0]   ld_x;
  logic               at_top, at_bot, ld_ok, tc_c;

  always_comb begin
    up_x   = {1'b0, ptr_q} + ONE_X;
    ld_x   = {1'b0, ld_val};
    at_top = (up_x >= DEPTH_X);
    at_bot = (ptr_q == '0);
    ld_ok  = (ld_x < DEPTH_X);
    ptr_d  = ptr_q;
    wrap_d = wrap_q;
    err_d  = 1'b0;
    tc_c   = 1'b0;
    if (c_reset || clr) begin
      ptr_d  = INIT_V;
      wrap_d = 1'b0;
    end else if (ld) begin
      if (ld_ok) ptr_d = ld_val;
      else       err_d = 1'b1;
    end else if (en) begin
      tc_c = dir ? at_top : at_bot;
`ifdef MOD_PTR_COUNTER_SAT_EN
      // boundary step holds; wrap_q never leaves its reset value
      if (dir && !at_top)      ptr_d = up_x[C_WIDTH-1:0];
      else if (!dir && !at_bot) ptr_d = ptr_q - C_WIDTH'(1);
`else
      if (dir) ptr_d = at_top ? '0 : up_x[C_WIDTH-1:0];
      else     ptr_d = at_bot ? TOP_V : ptr_q - C_WIDTH'(1);
      if (tc_c) wrap_d = ~wrap_q;
`endif
    end
  end

  always_ff @(posedge c_clk) begin
    if (c_reset) begin
      ptr_q  <= INIT_V;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign c_out  = ptr_q;
  assign c_next = ptr_d;
  assign c_wrap = wrap_q;
  assign tc     = tc_c;
  assign ld_err = err_q;

endmodule
